// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversamples the asynchronous line and recovers one byte per frame.
// Good bytes raise a one-cycle RX_Done_Sig; a low stop bit raises a one-cycle RX_Err_Sig instead.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_Pin_In,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       RX_Err_Sig,
  output logic       RX_Busy
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CNT_W    = $clog2(BIT_CNT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  generate
    if (BIT_CNT < 8) begin : g_bad_baud
      $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state, w_state_nx;
  logic             r_sync1, r_sync2, r_sync3;
  logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_nx;
  logic [2:0]       r_bit_idx, w_bit_idx_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic [7:0]       r_data, w_data_nx;
  logic             r_done, w_done_nx;
  logic             r_err, w_err_nx;
  logic             w_fall;
  logic             w_bit_end;
  logic             w_half_end;

  // r_sync2 is the synchronised line; r_sync3 only serves start-edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= RX_Pin_In;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_fall     = r_sync3 & ~r_sync2;
  assign w_bit_end  = (r_clk_cnt == BIT_LAST);
  assign w_half_end = (r_clk_cnt == HALF_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_clk_cnt <= w_clk_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shift   <= w_shift_nx;
      r_data    <= w_data_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clk_cnt_nx = '0;
    w_bit_idx_nx = r_bit_idx;
    w_shift_nx   = r_shift;
    w_data_nx    = r_data;
    w_done_nx    = 1'b0;
    w_err_nx     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nx = S_START;
      end
      S_START: begin
        if (w_half_end) begin
          // a line already back high at mid-start is treated as noise
          if (!r_sync2) begin
            w_state_nx   = S_DATA;
            w_bit_idx_nx = '0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_clk_cnt_nx = r_clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nx[r_bit_idx] = r_sync2;
          if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
          else w_bit_idx_nx = r_bit_idx + 3'd1;
        end else begin
          w_clk_cnt_nx = r_clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        // leave at mid-stop so a start bit right behind the stop bit is caught
        if (w_bit_end) begin
          if (r_sync2) begin
            w_data_nx  = r_shift;
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_err_nx   = 1'b1;
            w_state_nx = S_BREAK;
          end
        end else begin
          w_clk_cnt_nx = r_clk_cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (r_sync2) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign RX_Data     = r_data;
  assign RX_Done_Sig = r_done;
  assign RX_Err_Sig  = r_err;
  assign RX_Busy     = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial front end of the receive path: oversamples the asynchronous UART line (8N1, LSB first) and recovers one byte per frame.
- Feeds the downstream frame/checksum assembler with `RX_Data` plus a one-cycle `RX_Done_Sig` strobe per good byte.
- Flags framing errors separately and never strobes `RX_Done_Sig` for a bad frame, so the assembler only sees clean bytes.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- BIT_CNT, CLK_FREQ/BAUD (truncated), clocks per bit (derived localparam); must be >= 8, elaboration error otherwise.
- HALF_CNT, BIT_CNT/2 (truncated), clocks from start-edge detection to mid-start sample (derived).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- RX_Pin_In  input  1  raw serial line, idle high, asynchronous to CLK.
- RX_Data  output  8  last correctly received byte; held until the next good byte.
- RX_Done_Sig  output  1  one-CLK pulse, high in the same cycle RX_Data updates.
- RX_Err_Sig  output  1  one-CLK pulse on a framing error (stop bit sampled low).
- RX_Busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
Interface:
- One clock (CLK). Reset RST is asynchronous and active-high.
- Reset values: RX_Data=8'h00, RX_Done_Sig=0, RX_Err_Sig=0, RX_Busy=0, state=IDLE, counters=0, synchroniser flops=1 (idle line).

Input conditioning:
- RX_Pin_In passes through a 2-flop synchroniser, then a third flop for edge detection.
- Falling edge = previous synced sample 1 and current synced sample 0.

Counters:
- clk_cnt: width $clog2(BIT_CNT)+1, reloaded to 0 on every sample point.
- bit_idx: 3 bits, 0..7.

State machine (one-hot or binary, implementer's choice):
- IDLE: RX_Busy=0. On a falling edge, go to START with clk_cnt=0.
- START: count to HALF_CNT-1, then sample the synced line.
  - Sample is 0: go to DATA with clk_cnt=0 and bit_idx=0.
  - Sample is 1: glitch; return to IDLE with no pulse and no error.
- DATA: every BIT_CNT clocks, sample the line into shift register bit bit_idx (LSB first).
  - After bit_idx=7, go to STOP.
- STOP: after BIT_CNT clocks, sample the line.
  - Sample is 1: next cycle RX_Data<=shift register and RX_Done_Sig=1 for exactly one cycle; go to IDLE.
  - Sample is 0: next cycle RX_Err_Sig=1 for one cycle; RX_Data unchanged; go to BREAK.
- BREAK: stay until the synced line is high for one sample, then IDLE. A held-low line produces exactly one error pulse.

Timing rules:
- Latency from the stop-bit mid-sample to RX_Done_Sig is 1 CLK.
- From the raw start edge to RX_Done_Sig: 2 sync cycles + HALF_CNT + 9*BIT_CNT + 1 clocks, ±1 for edge phase.
- IDLE is re-entered at mid-stop bit, so a back-to-back next frame (start bit right after stop) is detected.
- RX_Done_Sig and RX_Err_Sig are never high together, and are never high for two consecutive cycles.
- A falling edge during START, DATA or STOP is ignored; the schedule is driven only by clk_cnt.
- RST asserted mid-frame aborts immediately to reset values. After release, a partial frame in progress on the line is only accepted if a new falling edge is seen.

Test Plan:
Setup: CLK_FREQ=1600000, BAUD=100000, so BIT_CNT=16 and HALF_CNT=8.
- Single byte 8'hA5, 16 clocks per bit, idle before and after -> exactly one RX_Done_Sig pulse; RX_Data=8'hA5 from that cycle on; RX_Err_Sig never high.
- Six back-to-back frames 8'h01,02,03,04,05,F1 with no idle gap -> six Done pulses with matching RX_Data in order; downstream assembler's checksum sums to 8'h00.
- Low glitch of 4 clocks on the idle line -> RX_Busy pulses high, then returns low; no Done or Err pulse; RX_Data unchanged.
- Frame 8'h3C with stop bit forced low, line held low 40 clocks, then high -> one RX_Err_Sig pulse, no Done; RX_Data keeps its previous value; a following good 8'h7E is received normally.
- RST asserted for 3 clocks during bit 4 of 8'hFF, then a clean 8'h55 -> all outputs 0 during reset; no pulse for the aborted frame; 8'h55 received with one Done pulse.
- Bits stretched to 17 clocks (+6% baud error) with byte 8'hC3 -> still received correctly with a single Done pulse.
